// File: rtl/cdb_broadcast_arbiter.sv
// rtl/cdb_broadcast_arbiter.sv - per-FU result slots arbitrated round-robin onto the CDB
module cdb_broadcast_arbiter #(
  parameter int N_FU       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int SLOT_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_FU-1:0]            fu_done,
  input  logic [N_FU*DATA_WIDTH-1:0] fu_result,
  input  logic [N_FU*TAG_WIDTH-1:0]  fu_tag,
  output logic [N_FU-1:0]            fu_queued,
  output logic                       cdb_valid,
  input  logic                       cdb_ready,
  output logic [DATA_WIDTH-1:0]      cdb_data,
  output logic [TAG_WIDTH-1:0]       cdb_tag,
  output logic [$clog2(N_FU)-1:0]    cdb_src,
  output logic [N_FU-1:0]            slot_full,
  output logic                       drop_err
);

  localparam int SW = $clog2(N_FU);
  localparam int PW = $clog2(SLOT_DEPTH);
  localparam int EW = DATA_WIDTH + TAG_WIDTH;

  logic [EW-1:0]   mem_q    [N_FU][SLOT_DEPTH];
  logic [PW-1:0]   wr_ptr_q [N_FU];
  logic [PW-1:0]   rd_ptr_q [N_FU];
  logic [PW:0]     cnt_q    [N_FU];
  logic [PW:0]     cnt_d    [N_FU];
  logic [N_FU-1:0] nonempty;
  logic [N_FU-1:0] pop;
  logic [N_FU-1:0] slot_full_q;
  logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]   grant_q, grant, rr_grant;
  logic [SW:0]     sum;
  logic            found;
  logic            lock_q, lock_d;
  logic            drop_err_q, drop_err_d;
  logic            fire;
  logic [EW-1:0]   head;

  always_comb begin
    for (int i = 0; i < N_FU; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
    end
  end

  // First nonempty slot at or after rr_ptr, wrapping around.
  always_comb begin
    rr_grant = '0;
    found    = 1'b0;
    sum      = '0;
    for (int k = 0; k < N_FU; k++) begin
      sum = {1'b0, rr_ptr_q} + (SW+1)'(k);
      if (sum >= (SW+1)'(N_FU)) sum = sum - (SW+1)'(N_FU);
      if (!found && nonempty[sum[SW-1:0]]) begin
        rr_grant = sum[SW-1:0];
        found    = 1'b1;
      end
    end
  end

  // A stalled grant stays frozen so the consumer sees a stable word.
  assign grant     = lock_q ? grant_q : rr_grant;
  assign cdb_valid = (|nonempty) & ~rst;
  assign fire      = cdb_valid & cdb_ready;
  assign head      = mem_q[grant][rd_ptr_q[grant]];
  assign cdb_data  = cdb_valid ? head[EW-1 -: DATA_WIDTH] : '0;
  assign cdb_tag   = cdb_valid ? head[TAG_WIDTH-1:0] : '0;
  assign cdb_src   = cdb_valid ? grant : '0;
  assign slot_full = slot_full_q;
  assign drop_err  = drop_err_q;

  always_comb begin
    for (int i = 0; i < N_FU; i++) begin
      pop[i]       = fire && (grant == SW'(i));
      fu_queued[i] = fu_done[i] && !rst && (!slot_full_q[i] || pop[i]);
      cnt_d[i]     = cnt_q[i];
      if (fu_queued[i] && !pop[i])      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (pop[i] && !fu_queued[i]) cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    drop_err_d = drop_err_q | (|(fu_done & ~fu_queued));
    if (fire) begin
      rr_ptr_d = (grant == SW'(N_FU-1)) ? '0 : grant + 1'b1;
      lock_d   = 1'b0;
    end else if (cdb_valid && !cdb_ready) begin
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      lock_q      <= 1'b0;
      drop_err_q  <= 1'b0;
      slot_full_q <= '0;
      for (int i = 0; i < N_FU; i++) begin
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant;
      lock_q     <= lock_d;
      drop_err_q <= drop_err_d;
      for (int i = 0; i < N_FU; i++) begin
        cnt_q[i]       <= cnt_d[i];
        slot_full_q[i] <= (cnt_d[i] == (PW+1)'(SLOT_DEPTH));
        if (fu_queued[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])       rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_FU; i++) begin
      if (fu_queued[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {fu_result[i*DATA_WIDTH +: DATA_WIDTH], fu_tag[i*TAG_WIDTH +: TAG_WIDTH]};
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// tb/tb_cdb_broadcast_arbiter.sv - directed self-checking bench for cdb_broadcast_arbiter
module tb_cdb_broadcast_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   fu_done;
  logic [127:0] fu_result;
  logic [27:0]  fu_tag;
  logic [3:0]   fu_queued;
  logic         cdb_valid;
  logic         cdb_ready;
  logic [31:0]  cdb_data;
  logic [6:0]   cdb_tag;
  logic [1:0]   cdb_src;
  logic [3:0]   slot_full;
  logic         drop_err;

  int checks   = 0;
  int failures = 0;

  cdb_broadcast_arbiter #(.N_FU(4), .DATA_WIDTH(32), .TAG_WIDTH(7), .SLOT_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fu_done(fu_done), .fu_result(fu_result), .fu_tag(fu_tag),
    .fu_queued(fu_queued), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_data(cdb_data),
    .cdb_tag(cdb_tag), .cdb_src(cdb_src), .slot_full(slot_full), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_done();
    fu_done = 4'b0000;
  endtask

  task automatic set_fu(input int i, input logic [6:0] tag, input logic [31:0] data);
    fu_done[i]          = 1'b1;
    fu_tag[i*7 +: 7]    = tag;
    fu_result[i*32 +: 32] = data;
  endtask

  task automatic do_reset();
    rst = 1'b1; cdb_ready = 1'b0; clr_done();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fu_result = '0; fu_tag = '0;
    do_reset();
    #1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", cdb_valid); end
    checks++; if (slot_full !== 4'b0000) begin failures++; $display("FAIL reset_full got=%b exp=0000", slot_full); end
    checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL reset_drop got=%0b exp=0", drop_err); end
    checks++; if (fu_queued !== 4'b0000) begin failures++; $display("FAIL reset_queued got=%b exp=0000", fu_queued); end
    checks++; if ({cdb_data, cdb_tag, cdb_src} !== '0) begin failures++; $display("FAIL reset_bus got=%0h/%0d/%0d exp=0", cdb_data, cdb_tag, cdb_src); end
  endtask

  task automatic test_single();
    do_reset();
    cdb_ready = 1'b1;
    set_fu(2, 7'd5, 32'hDEAD);
    #1;
    checks++; if (fu_queued !== 4'b0100) begin failures++; $display("FAIL single_queued got=%b exp=0100", fu_queued); end
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_nobypass got=%0b exp=0", cdb_valid); end
    tick(); clr_done(); #1;
    checks++; if ({cdb_valid, cdb_tag, cdb_src, cdb_data} !== {1'b1, 7'd5, 2'd2, 32'hDEAD})
      begin failures++; $display("FAIL single_out got=v%0b t%0d s%0d d%0h exp=v1 t5 s2 dDEAD", cdb_valid, cdb_tag, cdb_src, cdb_data); end
    tick(); #1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_empty got=%0b exp=0", cdb_valid); end
  endtask

  task automatic test_all_fu();
    do_reset();
    cdb_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_fu(i, 7'(10 + i), 32'h100 + i);
    #1;
    checks++; if (fu_queued !== 4'b1111) begin failures++; $display("FAIL all_queued got=%b exp=1111", fu_queued); end
    tick(); clr_done();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== {1'b1, 2'(k), 7'(10 + k), 32'h100 + k})
        begin failures++; $display("FAIL all_order%0d got=v%0b s%0d t%0d d%0h exp=s%0d t%0d", k, cdb_valid, cdb_src, cdb_tag, cdb_data, k, 10 + k); end
      tick();
    end
    #1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL all_empty got=%0b exp=0", cdb_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    set_fu(0, 7'd30, 32'hA0); set_fu(1, 7'd31, 32'hA1);
    tick();
    for (int c = 0; c < 5; c++) begin
      clr_done();
      if (c == 2) set_fu(1, 7'd32, 32'hA2);
      #1;
      checks++; if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== {1'b1, 2'd0, 7'd30, 32'hA0})
        begin failures++; $display("FAIL stall_hold%0d got=v%0b s%0d t%0d d%0h exp=s0 t30 dA0", c, cdb_valid, cdb_src, cdb_tag, cdb_data); end
      if (c == 2) begin
        checks++; if (fu_queued !== 4'b0010) begin failures++; $display("FAIL stall_queued got=%b exp=0010", fu_queued); end
      end
      tick();
    end
    clr_done(); cdb_ready = 1'b1; #1;
    checks++; if ({cdb_src, cdb_tag} !== {2'd0, 7'd30}) begin failures++; $display("FAIL stall_rel0 got=s%0d t%0d exp=s0 t30", cdb_src, cdb_tag); end
    tick(); #1;
    checks++; if ({cdb_src, cdb_tag} !== {2'd1, 7'd31}) begin failures++; $display("FAIL stall_rel1 got=s%0d t%0d exp=s1 t31", cdb_src, cdb_tag); end
    tick(); #1;
    checks++; if ({cdb_src, cdb_tag} !== {2'd1, 7'd32}) begin failures++; $display("FAIL stall_rel2 got=s%0d t%0d exp=s1 t32", cdb_src, cdb_tag); end
    tick(); #1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%0b exp=0", cdb_valid); end
  endtask

  task automatic test_lock();
    do_reset();
    cdb_ready = 1'b1;
    set_fu(1, 7'd33, 32'hB1);
    tick(); clr_done(); tick();
    cdb_ready = 1'b0;
    set_fu(0, 7'd34, 32'hB0);
    tick(); clr_done();
    set_fu(2, 7'd35, 32'hB2);
    tick(); clr_done(); #1;
    checks++; if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 2'd0, 7'd34}) begin failures++; $display("FAIL lock_hold got=v%0b s%0d t%0d exp=s0 t34", cdb_valid, cdb_src, cdb_tag); end
    cdb_ready = 1'b1;
    tick(); #1;
    checks++; if ({cdb_src, cdb_tag} !== {2'd2, 7'd35}) begin failures++; $display("FAIL lock_next got=s%0d t%0d exp=s2 t35", cdb_src, cdb_tag); end
    tick(); #1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL lock_empty got=%0b exp=0", cdb_valid); end
  endtask

  task automatic test_full_drop();
    do_reset();
    set_fu(3, 7'd20, 32'hC0); tick(); clr_done();
    set_fu(3, 7'd21, 32'hC1); #1;
    checks++; if (fu_queued !== 4'b1000) begin failures++; $display("FAIL drop_q2 got=%b exp=1000", fu_queued); end
    tick(); clr_done(); #1;
    checks++; if (slot_full !== 4'b1000) begin failures++; $display("FAIL drop_full got=%b exp=1000", slot_full); end
    set_fu(3, 7'd22, 32'hC2); #1;
    checks++; if (fu_queued !== 4'b0000) begin failures++; $display("FAIL drop_q3 got=%b exp=0000", fu_queued); end
    tick(); clr_done(); #1;
    checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL drop_err got=%0b exp=1", drop_err); end
    tick(); tick(); #1;
    checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL drop_sticky got=%0b exp=1", drop_err); end
    cdb_ready = 1'b1; #1;
    checks++; if ({cdb_src, cdb_tag, cdb_data} !== {2'd3, 7'd20, 32'hC0}) begin failures++; $display("FAIL drop_out0 got=s%0d t%0d d%0h exp=s3 t20 dC0", cdb_src, cdb_tag, cdb_data); end
    tick(); #1;
    checks++; if ({cdb_src, cdb_tag, cdb_data} !== {2'd3, 7'd21, 32'hC1}) begin failures++; $display("FAIL drop_out1 got=s%0d t%0d d%0h exp=s3 t21 dC1", cdb_src, cdb_tag, cdb_data); end
    tick(); #1;
    checks++; if ({cdb_valid, drop_err} !== 2'b01) begin failures++; $display("FAIL drop_end got=v%0b e%0b exp=v0 e1", cdb_valid, drop_err); end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    set_fu(3, 7'd40, 32'hD0); tick(); clr_done();
    set_fu(3, 7'd41, 32'hD1); tick(); clr_done();
    cdb_ready = 1'b1;
    set_fu(3, 7'd42, 32'hD2); #1;
    checks++; if ({slot_full, fu_queued, cdb_tag} !== {4'b1000, 4'b1000, 7'd40}) begin failures++; $display("FAIL pp_same got=f%b q%b t%0d exp=f1000 q1000 t40", slot_full, fu_queued, cdb_tag); end
    tick(); clr_done(); #1;
    checks++; if ({slot_full, drop_err, cdb_tag} !== {4'b1000, 1'b0, 7'd41}) begin failures++; $display("FAIL pp_occ got=f%b e%0b t%0d exp=f1000 e0 t41", slot_full, drop_err, cdb_tag); end
    tick(); #1;
    checks++; if ({slot_full, cdb_tag, cdb_data} !== {4'b0000, 7'd42, 32'hD2}) begin failures++; $display("FAIL pp_last got=f%b t%0d d%0h exp=f0000 t42 dD2", slot_full, cdb_tag, cdb_data); end
    tick(); #1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL pp_empty got=%0b exp=0", cdb_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_fu(1, 7'd50, 32'hE1); set_fu(3, 7'd60, 32'hE3); tick(); clr_done();
    set_fu(3, 7'd61, 32'hE4); tick(); clr_done();
    set_fu(3, 7'd62, 32'hE5); tick(); clr_done();
    cdb_ready = 1'b1; #1;
    checks++; if ({cdb_src, cdb_tag, drop_err} !== {2'd1, 7'd50, 1'b1}) begin failures++; $display("FAIL mid_pre got=s%0d t%0d e%0b exp=s1 t50 e1", cdb_src, cdb_tag, drop_err); end
    tick(); cdb_ready = 1'b0; tick();
    rst = 1'b1; cdb_ready = 1'b1; #1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL mid_inrst got=%0b exp=0", cdb_valid); end
    tick(); rst = 1'b0; cdb_ready = 1'b0; #1;
    checks++; if ({cdb_valid, slot_full, drop_err} !== 6'b0) begin failures++; $display("FAIL mid_post got=v%0b f%b e%0b exp=0", cdb_valid, slot_full, drop_err); end
    set_fu(0, 7'd70, 32'hF0); set_fu(3, 7'd71, 32'hF3); cdb_ready = 1'b1;
    tick(); clr_done(); #1;
    checks++; if ({cdb_src, cdb_tag} !== {2'd0, 7'd70}) begin failures++; $display("FAIL mid_rr got=s%0d t%0d exp=s0 t70", cdb_src, cdb_tag); end
    tick(); #1;
    checks++; if ({cdb_src, cdb_tag} !== {2'd3, 7'd71}) begin failures++; $display("FAIL mid_rr2 got=s%0d t%0d exp=s3 t71", cdb_src, cdb_tag); end
    tick(); #1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL mid_empty got=%0b exp=0", cdb_valid); end
  endtask

  initial begin
    rst = 1'b1; cdb_ready = 1'b0; fu_done = '0; fu_result = '0; fu_tag = '0;
    test_reset();
    test_single();
    test_all_fu();
    test_stall();
    test_lock();
    test_full_drop();
    test_full_pushpop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
